// File: rtl/linear_1d_activation_lanes.sv
// Multi-lane activation stage (bypass/ReLU/leaky/clip) with a 2-deep pipeline and an input skid entry.
// Optional per-packet clipped-lane counter on CLIP_COUNT, enabled by defining ACTIV_CLIP_COUNT_EN.
module linear_1d_activation_lanes #(
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned LANES              = 4,
  parameter int unsigned USER_WIDTH         = 2,
  parameter logic [3:0]  ACTIV_FUNC_BYPASS  = 4'h0,
  parameter logic [3:0]  ACTIV_FUNC_RELU    = 4'h1,
  parameter logic [3:0]  ACTIV_FUNC_LEAKY_RELU = 4'h2,
  parameter logic [3:0]  ACTIV_FUNC_CLIP    = 4'h5
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [3:0]                    ACTIV_FUNC,
  input  logic [DATA_WIDTH-1:0]         ACTIV_PARAM,
  output logic                          IN_READY,
  input  logic                          IN_VALID,
  input  logic [LANES*DATA_WIDTH-1:0]   IN_DATA,
  input  logic [USER_WIDTH-1:0]         IN_USER,
  input  logic                          IN_LAST,
  input  logic                          OUT_READY,
  output logic                          OUT_VALID,
  output logic [LANES*DATA_WIDTH-1:0]   OUT_DATA,
  output logic [USER_WIDTH-1:0]         OUT_USER,
  output logic                          OUT_LAST,
  output logic                          OUT_OVERFLOW
`ifdef ACTIV_CLIP_COUNT_EN
  ,
  output logic [15:0]                   CLIP_COUNT
`endif
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned BW  = LANES * DATA_WIDTH;
  localparam int unsigned LCW = $clog2(LANES + 1);

  logic                  r_in_pkt;
  logic [3:0]            r_func;
  logic [DW-1:0]         r_param;

  logic                  r_sk_valid;
  logic [BW-1:0]         r_sk_data;
  logic [USER_WIDTH-1:0] r_sk_user;
  logic                  r_sk_last;
  logic [3:0]            r_sk_func;
  logic [DW-1:0]         r_sk_param;

  logic                  r_s1_valid;
  logic [BW-1:0]         r_s1_data;
  logic [USER_WIDTH-1:0] r_s1_user;
  logic                  r_s1_last;
  logic                  r_s1_ovf;

  logic                  w_acc, w_adv, w_s1_load, w_sk_valid_nxt;
  logic [3:0]            w_eff_func, w_src_func;
  logic [DW-1:0]         w_eff_param, w_src_param;
  logic                  w_src_valid, w_src_last;
  logic [BW-1:0]         w_src_data, w_res;
  logic [USER_WIDTH-1:0] w_src_user;
  logic                  w_ovf;
  logic signed [DW-1:0]  w_x, w_y, w_ceil;
  int unsigned           w_sh;
`ifdef ACTIV_CLIP_COUNT_EN
  logic [LCW-1:0]        w_nclip;
  logic [16:0]           w_cnt_sum;
  logic [15:0]           w_cnt_sat;
  logic [15:0]           r_pkt_cnt, r_s1_cnt;
`endif

  assign w_acc      = IN_VALID & IN_READY;
  assign w_adv      = ~OUT_VALID | OUT_READY;
  assign w_s1_load  = ~r_s1_valid | w_adv;
  // Function/param are taken live only on the first beat of a packet.
  assign w_eff_func  = r_in_pkt ? r_func  : ACTIV_FUNC;
  assign w_eff_param = r_in_pkt ? r_param : ACTIV_PARAM;

  // A held skid beat always feeds S1 ahead of any new input.
  assign w_src_valid = r_sk_valid | w_acc;
  assign w_src_data  = r_sk_valid ? r_sk_data  : IN_DATA;
  assign w_src_user  = r_sk_valid ? r_sk_user  : IN_USER;
  assign w_src_last  = r_sk_valid ? r_sk_last  : IN_LAST;
  assign w_src_func  = r_sk_valid ? r_sk_func  : w_eff_func;
  assign w_src_param = r_sk_valid ? r_sk_param : w_eff_param;

  assign w_sk_valid_nxt = r_sk_valid ? ~w_s1_load : (w_acc & ~w_s1_load);

  // Per-lane activation on the selected source beat.
  always_comb begin
    w_res  = '0;
    w_ovf  = 1'b0;
    w_x    = '0;
    w_y    = '0;
`ifdef ACTIV_CLIP_COUNT_EN
    w_nclip = '0;
`endif
    w_sh = 32'(w_src_param[4:0]);
    if (w_sh > DW - 1) w_sh = DW - 1;
    w_ceil = $signed(w_src_param);
    if (w_ceil < 0) w_ceil = '0;
    for (int i = 0; i < LANES; i++) begin
      w_x = $signed(w_src_data[i*DW +: DW]);
      w_y = w_x;
      case (w_src_func)
        ACTIV_FUNC_RELU:       if (w_x < 0) w_y = '0;
        ACTIV_FUNC_LEAKY_RELU: if (w_x < 0) w_y = w_x >>> w_sh;
        ACTIV_FUNC_CLIP: begin
          if (w_x < 0) w_y = '0;
          else if (w_x > w_ceil) begin
            w_y   = w_ceil;
            w_ovf = 1'b1;
`ifdef ACTIV_CLIP_COUNT_EN
            w_nclip = w_nclip + LCW'(1);
`endif
          end
        end
        default: w_y = w_x;
      endcase
      w_res[i*DW +: DW] = w_y;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      IN_READY     <= 1'b0;
      r_in_pkt     <= 1'b0;
      r_func       <= '0;
      r_param      <= '0;
      r_sk_valid   <= 1'b0;
      r_sk_data    <= '0;
      r_sk_user    <= '0;
      r_sk_last    <= 1'b0;
      r_sk_func    <= '0;
      r_sk_param   <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_data    <= '0;
      r_s1_user    <= '0;
      r_s1_last    <= 1'b0;
      r_s1_ovf     <= 1'b0;
      OUT_VALID    <= 1'b0;
      OUT_DATA     <= '0;
      OUT_USER     <= '0;
      OUT_LAST     <= 1'b0;
      OUT_OVERFLOW <= 1'b0;
    end else begin
      if (w_acc) begin
        r_in_pkt <= ~IN_LAST;
        if (!r_in_pkt) begin
          r_func  <= ACTIV_FUNC;
          r_param <= ACTIV_PARAM;
        end
      end
      r_sk_valid <= w_sk_valid_nxt;
      IN_READY   <= ~w_sk_valid_nxt;
      if (!r_sk_valid && w_acc && !w_s1_load) begin
        r_sk_data  <= IN_DATA;
        r_sk_user  <= IN_USER;
        r_sk_last  <= IN_LAST;
        r_sk_func  <= w_eff_func;
        r_sk_param <= w_eff_param;
      end
      if (w_s1_load) begin
        r_s1_valid <= w_src_valid;
        if (w_src_valid) begin
          r_s1_data <= w_res;
          r_s1_user <= w_src_user;
          r_s1_last <= w_src_last;
          r_s1_ovf  <= w_ovf;
        end
      end
      if (w_adv) begin
        OUT_VALID <= r_s1_valid;
        if (r_s1_valid) begin
          OUT_DATA     <= r_s1_data;
          OUT_USER     <= r_s1_user;
          OUT_LAST     <= r_s1_last;
          OUT_OVERFLOW <= r_s1_ovf;
        end
      end
    end
  end

`ifdef ACTIV_CLIP_COUNT_EN
  assign w_cnt_sum = 17'(r_pkt_cnt) + 17'(w_nclip);
  assign w_cnt_sat = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];

  // Running count rides with each beat so the last beat carries the packet total.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pkt_cnt  <= '0;
      r_s1_cnt   <= '0;
      CLIP_COUNT <= '0;
    end else begin
      if (w_s1_load && w_src_valid) begin
        r_s1_cnt  <= w_cnt_sat;
        r_pkt_cnt <= w_src_last ? 16'h0 : w_cnt_sat;
      end
      if (w_adv && r_s1_valid) CLIP_COUNT <= r_s1_cnt;
    end
  end
`endif

endmodule

// File: doc/linear_1d_activation_lanes.md
LINEAR_1D_ACTIVATION_LANES -- requirements
Module: linear_1d_activation_lanes

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameters (name, default, meaning) SHALL be:
- DATA_WIDTH, 16, two's-complement lane width.
- LANES, 4, elements per beat (1..16).
- USER_WIDTH, 2, sideband width.
- ACTIV_FUNC_BYPASS/RELU/LEAKY_RELU/CLIP, 4'h0/4'h1/4'h2/4'h5, function codes.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- CLK, in, 1, clock.
- RESET, in, 1, synchronous active-high reset.
- ACTIV_FUNC, in, 4, function select.
- ACTIV_PARAM, in, DATA_WIDTH, leaky shift amount, or clip ceiling.
- IN_READY, out, 1, registered ready.
- IN_VALID, in, 1, input valid.
- IN_DATA, in, LANES*DATA_WIDTH, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- IN_USER, in, USER_WIDTH, sideband.
- IN_LAST, in, 1, packet end.
- OUT_READY, in, 1, downstream ready.
- OUT_VALID, OUT_DATA, OUT_USER, OUT_LAST, out, as inputs, result beat.
- OUT_OVERFLOW, out, 1, beat had an upper clip.

Function
REQ-004 A transfer SHALL occur on any edge where VALID and READY are both 1, on either side.
REQ-005 The datapath SHALL have two register stages: S1 (compute) and S2 (output), plus one skid entry; latency IN accept to OUT_VALID SHALL be 2 cycles when OUT_READY=1.
REQ-006 Throughput SHALL be one beat per clock while OUT_READY=1.
REQ-007 IN_READY SHALL be a flop output, 1 iff the skid entry is empty; an accepted beat with a stalled pipeline SHALL go to the skid entry, with no loss and no duplication.
REQ-008 ACTIV_FUNC and ACTIV_PARAM SHALL be latched on the first accepted beat of each packet (after reset, or after a beat with IN_LAST=1) and held until the IN_LAST beat is accepted; mid-packet changes SHALL be ignored.
REQ-009 Per-lane functions (x signed):
- BYPASS: y=x.
- RELU: y = x<0 ? 0 : x.
- LEAKY_RELU: y = x<0 ? x>>>p : x, arithmetic shift, p = ACTIV_PARAM[4:0] saturated to DATA_WIDTH-1.
- CLIP: y = x<0 ? 0 : (x>c ? c : x), c = ACTIV_PARAM treated as signed; c<0 SHALL be treated as c=0.
- Any other code: y=x.
REQ-010 OUT_OVERFLOW SHALL be 1 with a beat iff the function is CLIP and at least one lane had x>c; otherwise 0.
REQ-011 OUT_USER and OUT_LAST SHALL travel unchanged with their beat.
REQ-012 OUT_VALID=1 with OUT_READY=0 SHALL hold all OUT_* stable.

Reset
REQ-013 While RESET=1, these SHALL be 0 on the next edge: OUT_VALID, OUT_DATA, OUT_USER, OUT_LAST, OUT_OVERFLOW, skid, S1 and packet-start latch; IN_READY SHALL be 0 during RESET and 1 on the first cycle after release.
REQ-014 Reset mid-packet SHALL discard all in-flight beats; the next accepted beat SHALL be treated as a packet start.

Configuration
REQ-015 Macro ACTIV_CLIP_COUNT_EN:
- When defined, output CLIP_COUNT [15:0] SHALL count upper-clipped lanes of the current packet, saturate at 16'hFFFF, and be valid with the OUT_LAST beat.
- The count SHALL restart at 0 for the next packet.
- When undefined, the port and its logic SHALL be absent.

Verification
REQ-016 Bench scenarios:
- RELU, LANES=4, beat {-5,0,7,-32768}, OUT_READY=1 -> {0,0,7,0} two cycles later.
- LEAKY, p=2, lane -8 -> -2; lane -1 -> -1; lane 9 -> 9.
- CLIP, c=100, {150,-3,100,99} -> {100,0,100,99} with OUT_OVERFLOW=1; with ACTIV_CLIP_COUNT_EN, a 3-beat packet containing 5 clipped lanes -> CLIP_COUNT=5 on the last beat.
- OUT_READY held 0 for 3 cycles during a 6-beat stream -> IN_READY drops after the skid fills; all 6 beats emerge in order with none lost.
- ACTIV_FUNC changed RELU->BYPASS on beat 2 of a 4-beat packet -> all 4 beats use RELU; the next packet uses BYPASS.
- RESET asserted with 2 beats in flight -> OUT_VALID=0 the next cycle, and no stale beat after release.
